// File: rtl/tile_seq_fsm.sv
// tile_seq_fsm
// Layer sequencer: PREP once, then a counted loop of TRAN->COMP tiles,
// followed by a single DONE cycle. It supports a start/done handshake,
// abort, and a per-state watchdog with a sticky timeout flag.
// The state bus encoding is shared with the DMA and PE-array consumers
// and must not change.
module tile_seq_fsm #(
  parameter int CNT_W  = 8,
  parameter int WDOG_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_tiles,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              prep_done,
  input  logic              tran_done,
  input  logic              comp_done,
  input  logic              abort,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  tile_idx,
  output logic              tran_start,
  output logic              comp_start,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  // The encoding is fixed because downstream consumers decode the raw
  // state bus. Encodings 5-7 are illegal and are recovered to IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_TRAN = 3'd2,
    S_COMP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};
  localparam logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}};

  state_t              state_reg,      state_next;
  logic [CNT_W-1:0]    tile_idx_reg,   tile_idx_next;
  logic [CNT_W-1:0]    tiles_reg,      tiles_next;
  logic [WDOG_W-1:0]   limit_reg,      limit_next;
  logic [WDOG_W-1:0]   wdog_reg,       wdog_next;
  logic                timeout_reg,    timeout_next;
  logic                tran_start_reg, tran_start_next;
  logic                comp_start_reg, comp_start_next;

  logic                in_work;
  logic                exit_cond;
  logic                last_tile;
  logic                wdog_fire;
  logic                state_change;

  // in_work covers the three states that are guarded by the watchdog.
  assign in_work = (state_reg == S_PREP) ||
                   (state_reg == S_TRAN) ||
                   (state_reg == S_COMP);

  // Select the exit condition that belongs to the current state.
  // Done inputs that belong to other states are ignored.
  always_comb begin
    exit_cond = 1'b0;
    case (state_reg)
      S_PREP:  exit_cond = prep_done;
      S_TRAN:  exit_cond = tran_done;
      S_COMP:  exit_cond = comp_done;
      default: exit_cond = 1'b0;
    endcase
  end

  // COMP is only reachable with tiles_reg != 0, so the subtraction
  // cannot underflow whenever last_tile is used.
  assign last_tile = (tile_idx_reg == (tiles_reg - CNT_ONE));

  // The watchdog fires on the last allowed cycle of a stalled state.
  // A limit of zero disables it.
  assign wdog_fire = in_work && !exit_cond &&
                     (limit_reg != '0) &&
                     (wdog_reg == (limit_reg - WDOG_ONE));

  // Next-state logic. Priority is abort, then the exit condition, then
  // the watchdog.
  always_comb begin
    state_next    = state_reg;
    tile_idx_next = tile_idx_reg;
    tiles_next    = tiles_reg;
    limit_next    = limit_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      S_IDLE: begin
        // Abort has no effect in IDLE, so a start in the same cycle still
        // begins a new layer.
        if (start) begin
          state_next    = S_PREP;
          tiles_next    = cfg_tiles;
          limit_next    = wdog_limit;
          tile_idx_next = '0;
          timeout_next  = 1'b0;
        end
      end

      S_PREP: begin
        if (abort) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
        end else if (prep_done) begin
          state_next = (tiles_reg == '0) ? S_DONE : S_TRAN;
        end else if (wdog_fire) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
          timeout_next  = 1'b1;
        end
      end

      S_TRAN: begin
        if (abort) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
        end else if (tran_done) begin
          state_next = S_COMP;
        end else if (wdog_fire) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
          timeout_next  = 1'b1;
        end
      end

      S_COMP: begin
        if (abort) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
        end else if (comp_done) begin
          if (last_tile) begin
            state_next = S_DONE;
          end else begin
            state_next    = S_TRAN;
            tile_idx_next = tile_idx_reg + CNT_ONE;
          end
        end else if (wdog_fire) begin
          state_next    = S_IDLE;
          tile_idx_next = '0;
          timeout_next  = 1'b1;
        end
      end

      S_DONE: begin
        // DONE always lasts exactly one cycle. An abort here only
        // changes tile_idx.
        state_next = S_IDLE;
        if (abort) begin
          tile_idx_next = '0;
        end
      end

      default: begin
        // Recover from an illegal encoding. The sticky timeout is kept.
        state_next    = S_IDLE;
        tile_idx_next = '0;
      end
    endcase
  end

  assign state_change = (state_next != state_reg);

  // Watchdog counter: cleared on any state change, and counting up
  // (saturating) while a working state is stalled.
  always_comb begin
    wdog_next = wdog_reg;
    if (state_change) begin
      wdog_next = '0;
    end else if (in_work && !exit_cond && (wdog_reg != WDOG_MAX)) begin
      wdog_next = wdog_reg + WDOG_ONE;
    end
  end

  // Entry strobes are registered so they line up with the first cycle
  // in which the state bus shows TRAN or COMP.
  always_comb begin
    tran_start_next = (state_next == S_TRAN) && (state_reg != S_TRAN);
    comp_start_next = (state_next == S_COMP) && (state_reg != S_COMP);
  end

  // State and datapath registers, with an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      tile_idx_reg   <= '0;
      tiles_reg      <= '0;
      limit_reg      <= '0;
      wdog_reg       <= '0;
      timeout_reg    <= 1'b0;
      tran_start_reg <= 1'b0;
      comp_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tile_idx_reg   <= tile_idx_next;
      tiles_reg      <= tiles_next;
      limit_reg      <= limit_next;
      wdog_reg       <= wdog_next;
      timeout_reg    <= timeout_next;
      tran_start_reg <= tran_start_next;
      comp_start_reg <= comp_start_next;
    end
  end

  // busy and done are decoded straight from the state register, so they
  // add no latency. Illegal encodings decode to neither.
  assign state      = state_reg;
  assign tile_idx   = tile_idx_reg;
  assign tran_start = tran_start_reg;
  assign comp_start = comp_start_reg;
  assign busy       = in_work;
  assign done       = (state_reg == S_DONE);
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_tile_seq_fsm.sv
// Testbench for tile_seq_fsm. A cycle-level behavioural model is checked
// against the DUT on every falling edge. Directed scenarios also pin the
// state sequences and pulses to hand-computed literal values.
module tb_tile_seq_fsm;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  cfg_tiles;
  logic [15:0] wdog_limit;
  logic        prep_done;
  logic        tran_done;
  logic        comp_done;
  logic        abort;
  logic [2:0]  state;
  logic [7:0]  tile_idx;
  logic        tran_start;
  logic        comp_start;
  logic        busy;
  logic        done;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  tile_seq_fsm #(.CNT_W(8), .WDOG_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_tiles  (cfg_tiles),
    .wdog_limit (wdog_limit),
    .prep_done  (prep_done),
    .tran_done  (tran_done),
    .comp_done  (comp_done),
    .abort      (abort),
    .state      (state),
    .tile_idx   (tile_idx),
    .tran_start (tran_start),
    .comp_start (comp_start),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. Phases: 0 idle, 1 prep, 2 tran, 3 comp, 4 done.
  typedef struct packed {
    int st;
    int idx;
    int tiles;
    int limit;
    int wd;
    bit ts;
    bit cs;
    bit tmo;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t c, bit s_in, int cfg, int lim,
                                        bit pd, bit td, bit cd, bit ab);
    model_t n;
    bit     ex;
    int     nxt;
    n   = c;
    nxt = c.st;
    ex  = 1'b0;
    if (c.st == 1) ex = pd;
    else if (c.st == 2) ex = td;
    else if (c.st == 3) ex = cd;

    if (c.st == 0) begin
      if (s_in) begin
        nxt     = 1;
        n.tiles = cfg;
        n.limit = lim;
        n.idx   = 0;
        n.tmo   = 1'b0;
      end
    end else if (c.st > 4) begin
      nxt   = 0;
      n.idx = 0;
    end else if (ab) begin
      nxt   = 0;
      n.idx = 0;
    end else if (c.st == 4) begin
      nxt = 0;
    end else if (ex) begin
      if (c.st == 1) nxt = (c.tiles == 0) ? 4 : 2;
      else if (c.st == 2) nxt = 3;
      else if (c.idx == c.tiles - 1) nxt = 4;
      else begin
        nxt   = 2;
        n.idx = c.idx + 1;
      end
    end else if (c.limit != 0 && c.wd == c.limit - 1) begin
      nxt   = 0;
      n.idx = 0;
      n.tmo = 1'b1;
    end

    if (nxt != c.st) n.wd = 0;
    else if (c.st >= 1 && c.st <= 3 && !ex && c.wd < 65535) n.wd = c.wd + 1;

    n.ts = (nxt == 2) && (c.st != 2);
    n.cs = (nxt == 3) && (c.st != 3);
    n.st = nxt;
    return n;
  endfunction

  // Advance the model on the same edges as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else m <= model_step(m, start, int'(cfg_tiles), int'(wdog_limit),
                         prep_done, tran_done, comp_done, abort);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    chk("model.state",      32'(state),      32'(m.st));
    chk("model.tile_idx",   32'(tile_idx),   32'(m.idx));
    chk("model.tran_start", 32'(tran_start), 32'(m.ts));
    chk("model.comp_start", 32'(comp_start), 32'(m.cs));
    chk("model.busy",       32'(busy),       32'(m.st >= 1 && m.st <= 3));
    chk("model.done",       32'(done),       32'(m.st == 4));
    chk("model.timeout",    32'(timeout),    32'(m.tmo));
  end

  // Wait one cycle, then check the state bus on both the DUT and the
  // model against a literal value.
  task automatic cyc(input string nm, input int st);
    @(negedge clk);
    chk({nm, ".state"}, 32'(state), st);
    chk({nm, ".model_state"}, 32'(m.st), st);
    $display("cycle %s: state=%0d tile_idx=%0d ts=%0d cs=%0d done=%0d timeout=%0d",
             nm, state, tile_idx, tran_start, comp_start, done, timeout);
  endtask

  // Check the output pins against literal values. An idx of -1 skips the
  // tile_idx check.
  task automatic pins(input string nm, input int idx, input int ts, input int cs,
                      input int dn, input int tmo);
    if (idx >= 0) chk({nm, ".tile_idx"}, 32'(tile_idx), idx);
    chk({nm, ".tran_start"}, 32'(tran_start), ts);
    chk({nm, ".comp_start"}, 32'(comp_start), cs);
    chk({nm, ".done"}, 32'(done), dn);
    chk({nm, ".timeout"}, 32'(timeout), tmo);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b0; start = 1'b0; cfg_tiles = '0; wdog_limit = '0;
    prep_done = 1'b1; tran_done = 1'b1; comp_done = 1'b1; abort = 1'b0;

    // Reset state.
    cyc("reset", 0);
    pins("reset", 0, 0, 0, 0, 0);
    chk("reset.busy", 32'(busy), 0);
    reset = 1'b1;

    // Normal 3-tile layer.
    cyc("t1", 0); start = 1'b1; cfg_tiles = 8'd3; wdog_limit = 16'd0;
    cyc("t1", 1); start = 1'b0; pins("t1p", 0, 0, 0, 0, 0);
    chk("t1.busy", 32'(busy), 1);
    cyc("t1", 2); pins("t1a", 0, 1, 0, 0, 0);
    cyc("t1", 3); pins("t1b", 0, 0, 1, 0, 0);
    cyc("t1", 2); pins("t1c", 1, 1, 0, 0, 0);
    cyc("t1", 3); pins("t1d", 1, 0, 1, 0, 0);
    cyc("t1", 2); pins("t1e", 2, 1, 0, 0, 0);
    cyc("t1", 3); pins("t1f", 2, 0, 1, 0, 0);
    cyc("t1", 4); pins("t1g", -1, 0, 0, 1, 0);
    chk("t1.busy_done", 32'(busy), 0);
    cyc("t1", 0); pins("t1h", -1, 0, 0, 0, 0);

    // Zero tiles; abort in IDLE together with start is still accepted.
    cyc("t2", 0); start = 1'b1; abort = 1'b1; cfg_tiles = 8'd0;
    cyc("t2", 1); start = 1'b0; abort = 1'b0;
    cyc("t2", 4); pins("t2", 0, 0, 0, 1, 0);
    cyc("t2", 0); pins("t2b", 0, 0, 0, 0, 0);

    // Watchdog: limit 4 with TRAN stalled.
    cyc("t3", 0); start = 1'b1; cfg_tiles = 8'd2; wdog_limit = 16'd4; tran_done = 1'b0;
    cyc("t3", 1); start = 1'b0;
    cyc("t3", 2); pins("t3a", 0, 1, 0, 0, 0);
    cyc("t3", 2); pins("t3b", 0, 0, 0, 0, 0);
    cyc("t3", 2);
    cyc("t3", 2);
    cyc("t3", 0); pins("t3c", 0, 0, 0, 0, 1);
    cyc("t3", 0); pins("t3d", 0, 0, 0, 0, 1);
    // Follow-up: the next start clears timeout.
    start = 1'b1; wdog_limit = 16'd0; tran_done = 1'b1;
    cyc("t3f", 1); start = 1'b0; pins("t3f", 0, 0, 0, 0, 0);
    cyc("t3f", 2); cyc("t3f", 3); cyc("t3f", 2); cyc("t3f", 3);
    cyc("t3f", 4); pins("t3g", 1, 0, 0, 1, 0);
    cyc("t3f", 0);

    // Abort in COMP takes priority over comp_done.
    cyc("t4", 0); start = 1'b1; cfg_tiles = 8'd3;
    cyc("t4", 1); start = 1'b0;
    cyc("t4", 2); cyc("t4", 3); cyc("t4", 2);
    cyc("t4", 3); pins("t4a", 1, 0, 1, 0, 0); abort = 1'b1;
    cyc("t4", 0); pins("t4b", 0, 0, 0, 0, 0); abort = 1'b0;
    cyc("t4", 0);

    // A start during TRAN is ignored.
    cyc("t5", 0); start = 1'b1; cfg_tiles = 8'd2;
    cyc("t5", 1); start = 1'b0;
    cyc("t5", 2); start = 1'b1; cfg_tiles = 8'd7;
    cyc("t5", 3); start = 1'b0; cfg_tiles = 8'd0;
    cyc("t5", 2); pins("t5a", 1, 1, 0, 0, 0);
    cyc("t5", 3);
    cyc("t5", 4); pins("t5b", 1, 0, 0, 1, 0);
    cyc("t5", 0);

    // Asynchronous reset in COMP with tile_idx 1.
    cyc("t6", 0); start = 1'b1; cfg_tiles = 8'd3;
    cyc("t6", 1); start = 1'b0;
    cyc("t6", 2); cyc("t6", 3); cyc("t6", 2);
    cyc("t6", 3); pins("t6a", 1, 0, 1, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("t6r.state", 32'(state), 0);
    chk("t6r.busy", 32'(busy), 0);
    pins("t6r", 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;
    start = 1'b1; cfg_tiles = 8'd1;
    cyc("t6n", 1); start = 1'b0;
    cyc("t6n", 2); pins("t6n", 0, 1, 0, 0, 0);
    cyc("t6n", 3); pins("t6o", 0, 0, 1, 0, 0);
    cyc("t6n", 4); pins("t6p", 0, 0, 0, 1, 0);
    cyc("t6n", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
